// File: rtl/whack_round_ctrl.sv
// -----------------------------------------------------------------------------
// whack_round_ctrl
//
// Game-round sequencer for the whack-an-engineer datapath. Each round asks the
// pseudo-RNG for a new one-hot target, lights it for up to ON_CYCLES cycles,
// judges the first button rising edge as a hit or a miss (or a timeout miss),
// then keeps all targets dark for GAP_CYCLES cycles. After ROUND_COUNT rounds
// the block parks in DONE with the final scores held for the display logic.
//
// Parameters
//   ON_CYCLES    maximum cycles a target stays lit (>= 2)
//   GAP_CYCLES   dark cycles between targets (>= 1)
//   ROUND_COUNT  targets per game (1..255)
//
// Ports
//   clock       in   system clock, single domain
//   reset       in   synchronous active-high reset, returns to IDLE
//   start       in   begins a game when sampled high in IDLE or DONE
//   buttons     in   [4:0] debounced player buttons, bit i = target i
//   rng_data    in   [4:0] one-hot value from the RNG
//   rng_gen     out  one-cycle generate pulse to the RNG (high only in REQ)
//   led_target  out  [4:0] one-hot lit target, 0 when dark
//   score       out  [7:0] hits this game, saturating
//   misses      out  [7:0] misses this game, saturating
//   round_idx   out  [7:0] rounds completed this game
//   hit_pulse   out  one-cycle pulse on a hit
//   miss_pulse  out  one-cycle pulse on a miss
//   busy        out  high in every state except IDLE and DONE
//   done        out  high in DONE
//
// Every output is a flop. The next values of all state and outputs are formed
// in one combinational block and captured in one sequential block, so the
// outputs always describe the state the block is in during that cycle.
// -----------------------------------------------------------------------------
module whack_round_ctrl #(
    parameter int ON_CYCLES   = 50000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int ROUND_COUNT = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] buttons,
    input  logic [4:0] rng_data,
    output logic       rng_gen,
    output logic [4:0] led_target,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round_idx,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       busy,
    output logic       done
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int ON_W  = $clog2(ON_CYCLES) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [ON_W-1:0]  ON_LAST    = ON_W'(ON_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       ROUND_LAST = 8'(ROUND_COUNT);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_SHOW = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [4:0] v);
        return (v != 5'b00000) && ((v & (v - 5'b00001)) == 5'b00000);
    endfunction

    // Rotate a 5-bit target left by one position, bit 4 wrapping to bit 0.
    function automatic logic [4:0] rotl1(input logic [4:0] v);
        return {v[3:0], v[4]};
    endfunction

    // Increment an 8-bit counter, sticking at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]       state_r;
    logic [ON_W-1:0]  on_timer_r;
    logic [GAP_W-1:0] gap_timer_r;
    logic [4:0]       target_r;
    logic [4:0]       prev_target_r;
    logic [4:0]       btn_hist_r;
    logic [7:0]       score_r;
    logic [7:0]       misses_r;
    logic [7:0]       round_r;
    logic             rng_gen_r;
    logic [4:0]       led_r;
    logic             hit_r;
    logic             miss_r;
    logic             busy_r;
    logic             done_r;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [2:0]       state_s;
    logic [ON_W-1:0]  on_timer_s;
    logic [GAP_W-1:0] gap_timer_s;
    logic [4:0]       target_s;
    logic [4:0]       prev_target_s;
    logic [7:0]       score_s;
    logic [7:0]       misses_s;
    logic [7:0]       round_s;
    logic             hit_s;
    logic             miss_s;
    logic [4:0]       rise_s;
    logic [4:0]       cand_s;
    logic [4:0]       pick_s;

    // A rise is a button that is high now but was low last cycle. Because the
    // history tracks every cycle, a button already held when SHOW starts
    // never counts as a press.
    assign rise_s = buttons & ~btn_hist_r;

    // Target selection from the RNG sample: sanitise to one-hot, then avoid
    // repeating the previous target.
    always_comb begin
        cand_s = 5'b00001;
        pick_s = 5'b00001;
        if (is_one_hot(rng_data)) begin
            cand_s = rng_data;
        end else begin
            cand_s = 5'b00001;
        end
        if (cand_s == prev_target_r) begin
            pick_s = rotl1(cand_s);
        end else begin
            pick_s = cand_s;
        end
    end

    // Round sequencing: next state, timers, target and score bookkeeping.
    always_comb begin
        state_s       = state_r;
        on_timer_s    = on_timer_r;
        gap_timer_s   = gap_timer_r;
        target_s      = target_r;
        prev_target_s = prev_target_r;
        score_s       = score_r;
        misses_s      = misses_r;
        round_s       = round_r;
        hit_s         = 1'b0;
        miss_s        = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    score_s  = 8'd0;
                    misses_s = 8'd0;
                    round_s  = 8'd0;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = state_r;
                end
            end

            ST_REQ: begin
                state_s = ST_LOAD;
            end

            ST_LOAD: begin
                target_s      = pick_s;
                prev_target_s = pick_s;
                on_timer_s    = {ON_W{1'b0}};
                state_s       = ST_SHOW;
            end

            ST_SHOW: begin
                // A press on the final lit cycle is still judged as a press;
                // the timeout only applies when nothing rose.
                if (rise_s != 5'b00000) begin
                    if (rise_s == target_r) begin
                        hit_s   = 1'b1;
                        score_s = sat_inc(score_r);
                    end else begin
                        miss_s   = 1'b1;
                        misses_s = sat_inc(misses_r);
                    end
                    round_s     = sat_inc(round_r);
                    gap_timer_s = {GAP_W{1'b0}};
                    state_s     = ST_GAP;
                end else if (on_timer_r == ON_LAST) begin
                    miss_s      = 1'b1;
                    misses_s    = sat_inc(misses_r);
                    round_s     = sat_inc(round_r);
                    gap_timer_s = {GAP_W{1'b0}};
                    state_s     = ST_GAP;
                end else begin
                    on_timer_s  = on_timer_r + {{(ON_W-1){1'b0}}, 1'b1};
                end
            end

            ST_GAP: begin
                // round_idx already counts this round, so compare it directly
                // against the game length when the gap expires.
                if (gap_timer_r == GAP_LAST) begin
                    if (round_r == ROUND_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    gap_timer_s = gap_timer_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs, all decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            on_timer_r    <= {ON_W{1'b0}};
            gap_timer_r   <= {GAP_W{1'b0}};
            target_r      <= 5'b00000;
            prev_target_r <= 5'b00000;
            btn_hist_r    <= 5'b00000;
            score_r       <= 8'd0;
            misses_r      <= 8'd0;
            round_r       <= 8'd0;
            rng_gen_r     <= 1'b0;
            led_r         <= 5'b00000;
            hit_r         <= 1'b0;
            miss_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            on_timer_r    <= on_timer_s;
            gap_timer_r   <= gap_timer_s;
            target_r      <= target_s;
            prev_target_r <= prev_target_s;
            btn_hist_r    <= buttons;
            score_r       <= score_s;
            misses_r      <= misses_s;
            round_r       <= round_s;
            rng_gen_r     <= (state_s == ST_REQ);
            led_r         <= (state_s == ST_SHOW) ? target_s : 5'b00000;
            hit_r         <= hit_s;
            miss_r        <= miss_s;
            busy_r        <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r        <= (state_s == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rng_gen    = rng_gen_r;
    assign led_target = led_r;
    assign score      = score_r;
    assign misses     = misses_r;
    assign round_idx  = round_r;
    assign hit_pulse  = hit_r;
    assign miss_pulse = miss_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whack_round_ctrl
//
// Self-checking bench for whack_round_ctrl with ON_CYCLES=8, GAP_CYCLES=4,
// ROUND_COUNT=3. A game-level reference model (target choice, judged outcome,
// saturating scores) predicts what each round must show; directed games cover
// the listed scenarios and randomized games follow.
// -----------------------------------------------------------------------------
module tb_whack_round_ctrl;

    localparam int ON  = 8;
    localparam int GAP = 4;
    localparam int RC  = 3;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] buttons;
    logic [4:0] rng_data;
    logic       rng_gen;
    logic [4:0] led_target;
    logic [7:0] score;
    logic [7:0] misses;
    logic [7:0] round_idx;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       busy;
    logic       done;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [4:0] m_prev;
    logic [7:0] m_score;
    logic [7:0] m_miss;
    logic [7:0] m_round;
    logic [4:0] hold_v;

    whack_round_ctrl #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .ROUND_COUNT(RC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .buttons   (buttons),
        .rng_data  (rng_data),
        .rng_gen   (rng_gen),
        .led_target(led_target),
        .score     (score),
        .misses    (misses),
        .round_idx (round_idx),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Target the round should light: non-one-hot samples become target 0,
    // a repeat of the previous target moves one position up (4 wraps to 0).
    function automatic logic [4:0] model_target(input logic [4:0] rng, input logic [4:0] prev);
        logic [4:0] c;
        c = ($countones(rng) == 1) ? rng : 5'b00001;
        if (c == prev) begin
            c = (c == 5'b10000) ? 5'b00001 : 5'(c * 2);
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] v);
        int t;
        t = int'(v) + 1;
        if (t > 255) t = 255;
        return 8'(t);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_gen"},   rng_gen,    0);
        check_val({tag, "_led"},   led_target, 0);
        check_val({tag, "_score"}, score,      0);
        check_val({tag, "_miss"},  misses,     0);
        check_val({tag, "_round"}, round_idx,  0);
        check_val({tag, "_hitp"},  hit_pulse,  0);
        check_val({tag, "_missp"}, miss_pulse, 0);
        check_val({tag, "_busy"},  busy,       0);
        check_val({tag, "_done"},  done,       0);
    endtask

    // Pulse start for one cycle; the block must enter REQ with cleared scores.
    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_score = 8'd0;
        m_miss  = 8'd0;
        m_round = 8'd0;
        check_val("start_busy",  busy,      1);
        check_val("start_done",  done,      0);
        check_val("start_score", score,     0);
        check_val("start_miss",  misses,    0);
        check_val("start_round", round_idx, 0);
    endtask

    // One full round, entered just after the edge into REQ. press_at < 0 means
    // no press; pat_in == 0 means press exactly the lit target.
    task automatic play_round(input logic [4:0] rng, input int press_at, input logic [4:0] pat_in);
        logic [4:0] exp_t;
        logic [4:0] pat;
        bit judged;
        bit hit;
        rng_data = rng;
        check_val("req_gen",  rng_gen,    1);
        check_val("req_busy", busy,       1);
        check_val("req_led",  led_target, 0);
        tick();
        check_val("load_gen", rng_gen,    0);
        check_val("load_led", led_target, 0);
        tick();
        exp_t  = model_target(rng, m_prev);
        m_prev = exp_t;
        check_val("show_led", led_target, exp_t);
        check_val("show_gen", rng_gen,    0);
        pat    = (pat_in == 5'b00000) ? exp_t : pat_in;
        judged = 1'b0;
        hit    = 1'b0;
        for (int s = 0; s < ON && !judged; s++) begin
            if (s == press_at) buttons = pat;
            tick();
            buttons = hold_v;
            if (s == press_at) begin
                judged = 1'b1;
                hit    = (pat == exp_t);
            end else if (s == ON - 1) begin
                judged = 1'b1;
                hit    = 1'b0;
            end
            if (judged) begin
                if (hit) m_score = sat_add(m_score);
                else     m_miss  = sat_add(m_miss);
                m_round = sat_add(m_round);
                check_val("judge_hitp",  hit_pulse,  32'(hit));
                check_val("judge_missp", miss_pulse, 32'(!hit));
                check_val("judge_score", score,      m_score);
                check_val("judge_miss",  misses,     m_miss);
                check_val("judge_round", round_idx,  m_round);
                check_val("judge_led",   led_target, 0);
            end else begin
                check_val("show_hitp",  hit_pulse,  0);
                check_val("show_missp", miss_pulse, 0);
                check_val("show_led_h", led_target, exp_t);
            end
        end
        for (int g = 1; g <= GAP; g++) begin
            if (g == 1 && hold_v == 5'b00000) buttons = 5'($urandom_range(1, 31));
            tick();
            buttons = hold_v;
            if (g < GAP) begin
                check_val("gap_hitp",  hit_pulse,  0);
                check_val("gap_missp", miss_pulse, 0);
                check_val("gap_led",   led_target, 0);
                check_val("gap_score", score,      m_score);
                check_val("gap_miss",  misses,     m_miss);
            end else if (m_round == 8'(RC)) begin
                check_val("end_done",  done,    1);
                check_val("end_busy",  busy,    0);
                check_val("end_gen",   rng_gen, 0);
            end else begin
                check_val("next_gen",  rng_gen, 1);
                check_val("next_done", done,    0);
            end
        end
    endtask

    // Stimulus sequence: reset, directed games, mid-game reset, held button,
    // then randomized games.
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        buttons  = 5'b00000;
        rng_data = 5'b00000;
        hold_v   = 5'b00000;
        m_prev   = 5'b00000;
        m_score  = 8'd0;
        m_miss   = 8'd0;
        m_round  = 8'd0;
        tick();
        tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();
        check_idle_outputs("idle");

        // Game A: hit on 3rd SHOW cycle, timeout, repeated RNG value then hit.
        start_game();
        play_round(5'b00100, 2, 5'b00000);
        check_val("a_r1_score", score, 1);
        play_round(5'b01000, -1, 5'b00000);
        play_round(5'b01000, 5, 5'b00000);
        check_val("a_prev_rot", m_prev == 5'b10000, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("done_hold_done",  done,      1);
            check_val("done_hold_score", score,     2);
            check_val("done_hold_miss",  misses,    1);
            check_val("done_hold_round", round_idx, 3);
            check_val("done_hold_led",   led_target, 0);
        end

        // Game B from DONE: invalid RNG values and multi-button presses.
        start_game();
        play_round(5'b00000, 3, 5'b00101);
        play_round(5'b00100, 4, 5'b00101);
        play_round(5'b00011, ON - 1, 5'b00000);
        check_val("b_score", score,  1);
        check_val("b_miss",  misses, 2);

        // Reset in the middle of SHOW.
        start_game();
        play_round(5'b00010, 1, 5'b00000);
        rng_data = 5'b10000;
        tick();
        tick();
        check_val("mid_led", led_target, model_target(5'b10000, m_prev));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midrst");
        m_prev = 5'b00000;

        // Target button held from before the round: no edge, so a timeout.
        hold_v  = 5'b00100;
        buttons = hold_v;
        tick();
        start_game();
        play_round(5'b00100, -1, 5'b00000);
        check_val("held_score", score,  0);
        check_val("held_miss",  misses, 1);
        hold_v  = 5'b00000;
        buttons = hold_v;
        play_round(5'($urandom_range(0, 31)), int'($urandom_range(0, 7)), 5'b00000);
        play_round(5'($urandom_range(0, 31)), -1, 5'b00000);

        // Randomized games.
        for (int gm = 0; gm < 6; gm++) begin
            start_game();
            for (int r = 0; r < RC; r++) begin
                int pa;
                logic [4:0] pt;
                pa = int'($urandom_range(0, ON + 1)) - 1;
                if (pa > ON - 1) pa = -1;
                pt = ($urandom_range(0, 1) == 0) ? 5'b00000 : 5'($urandom_range(1, 31));
                play_round(5'($urandom_range(0, 31)), pa, pt);
            end
            check_val("rnd_score", score,     m_score);
            check_val("rnd_miss",  misses,    m_miss);
            check_val("rnd_round", round_idx, RC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/whack_round_ctrl.md
# whack_round_ctrl

Game-round sequencer for the whack-an-engineer datapath. Requests a one-hot target from the pseudo-RNG, lights that target for a bounded window, and judges player button presses as hit or miss. Runs a fixed number of rounds per game and keeps saturating hit/miss scores for the display logic. Sits between the start/button inputs, the RNG, and the LED/score outputs.

## Interface
- ON_CYCLES, 50000000: maximum cycles a target stays lit (≥2)
- GAP_CYCLES, 12500000: dark cycles between targets (≥1)
- ROUND_COUNT, 20: targets per game (1..255)
- clock  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  level/pulse; begins a game when sampled high in IDLE or DONE
- buttons  input  5  debounced player buttons, active-high, bit i = target i
- rng_data  input  5  one-hot value from the RNG
- rng_gen  output  1  registered one-cycle pulse to the RNG's generate enable
- led_target  output  5  one-hot lit target; 0 when nothing is lit
- score  output  8  hits this game, saturating at 255
- misses  output  8  misses this game (timeout or wrong press), saturating at 255
- round_idx  output  8  rounds completed this game
- hit_pulse  output  1  one-cycle pulse on a hit
- miss_pulse  output  1  one-cycle pulse on a miss
- busy  output  1  high in all states except IDLE and DONE
- done  output  1  high in DONE

## Operation
- States: IDLE, REQ, LOAD, SHOW, GAP, DONE. On reset: IDLE; all outputs 0; stored previous target 0; button history 0.
- IDLE/DONE + start=1: clear score, misses, round_idx → REQ. In all other states start is ignored.
- REQ (1 cycle): rng_gen=1 → LOAD. rng_gen is a flop output, high only in REQ.
- LOAD (1 cycle): sample rng_data. Not exactly one-hot (zero or multiple bits) → use 5'b00001. Equal to the previous target → rotate left by one (bit 4 wraps to bit 0). Store the result as target and previous target → SHOW.
- SHOW: led_target=target; timer counts 0..ON_CYCLES-1.
  - The button history register updates every cycle in every state. rise = buttons & ~history. A button held across state entry therefore produces no edge.
  - rise ≠ 0 and rise == target → hit: score+1, hit_pulse → GAP.
  - rise ≠ 0 and any bit outside target (including target plus another bit in the same cycle) → miss: misses+1, miss_pulse → GAP.
  - No rise on timer cycle ON_CYCLES-1 → timeout miss → GAP. A press on that same cycle is judged as a press, not a timeout.
- GAP: led_target=0; GAP_CYCLES cycles. Presses here are ignored (not counted). round_idx increments on GAP entry.
  - At GAP end: round_idx == ROUND_COUNT → DONE, else → REQ.
- DONE: score, misses and round_idx hold until the next start.
- Scores saturate; no wrap. Timer widths are $clog2 of the parameter plus 1.
- reset mid-game (any state): immediate return to IDLE with all values cleared; rng_gen drops the same edge.

## Timing
- start high in IDLE at edge N:
  - REQ and rng_gen=1 during cycle N+1.
  - LOAD samples rng_data at edge N+2.
  - led_target valid from N+3.
- The RNG updates on the rising edge of rng_gen. The LOAD sample occurs one full cycle later.
- Hit/miss judgement: edge K sees the rise, so hit_pulse/miss_pulse and score/misses update after edge K. GAP and led_target=0 follow at the same edge.
- SHOW lasts at most ON_CYCLES cycles. Round period without a press = 2 + ON_CYCLES + GAP_CYCLES cycles.
- The pulses are exactly one cycle wide and mutually exclusive.

## Test plan
Use ON_CYCLES=8, GAP_CYCLES=4, ROUND_COUNT=3 for all scenarios.
- Reset then start, rng_data=5'b00100: rng_gen pulses once at cycle N+1; led_target=5'b00100 from N+3; busy=1.
- Press button 2 on the 3rd SHOW cycle: hit_pulse once; score=1; led_target=0 next cycle; round_idx=1.
- No press for 8 SHOW cycles: miss_pulse on cycle 8; misses=1. Pressing 5'b00101 simultaneously while target=5'b00100 also gives a miss, not a hit.
- rng_data=5'b01000 twice in a row: second target is 5'b10000. rng_data=5'b00000 or 5'b00011 gives target 5'b00001.
- Three rounds with hit, timeout, hit: done=1, score=2, misses=1, round_idx=3, held. A start in DONE clears all three and restarts.
- Assert reset during SHOW with score=1: next cycle IDLE; led_target=0; score=0; busy=0. A button held through GAP into the next SHOW produces no hit.
